tribus_resolver: RTL and testbench
==================================

TRIBUS_RESOLVER -- requirements
Module: tribus_resolver

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bus width in bits (1..64).
REQ-002 SHALL have parameter NCH, default 4, meaning number of driving channels (2..16).
REQ-003 SHALL have parameter NET_MODE, default 0, meaning 0=TRI, 1=WAND, 2=WOR.
REQ-004 SHALL have parameter PULL_MODE, default 0, meaning 0=none, 1=pull-down (tri0), 2=pull-up (tri1), 3=keeper (trireg).
REQ-005 SHALL have parameter DECAY, default 16, meaning keeper hold limit in undriven cycles (1..65535).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port drv_en, input, NCH bits: channel i drives the bus this cycle.
REQ-009 SHALL have port drv_data, input, NCH*WIDTH bits: channel i value in slice [i*WIDTH +: WIDTH].
REQ-010 SHALL have port cnt_clr, input, 1 bit: synchronous clear of conflict_cnt.
REQ-011 SHALL have port bus_q, output, WIDTH bits: registered resolved bus value.
REQ-012 SHALL have port bus_zmask, output, WIDTH bits: registered; 1 = bit floating (high-Z equivalent).
REQ-013 SHALL have port conflict_mask, output, WIDTH bits: registered; 1 = bit had disagreeing drivers.
REQ-014 SHALL have port conflict_cnt, output, 16 bits: saturating count of conflict cycles.

Function
REQ-015 All outputs SHALL be registered; resolution of cycle N inputs SHALL appear after edge N (latency 1).
REQ-016 Driven bit (any drv_en set), TRI: value from lowest-index enabled channel; conflict_mask bit = 1 iff enabled channels disagree.
REQ-017 Driven bit, WAND: AND over enabled channels; WOR: OR over enabled channels; conflict_mask SHALL stay 0.
REQ-018 Undriven bus (drv_en all 0), PULL_MODE 0: bus_zmask all ones; bus_q holds previous value.
REQ-019 Undriven bus, PULL_MODE 1: bus_q = 0, bus_zmask = 0.
REQ-020 Undriven bus, PULL_MODE 2: bus_q = all ones, bus_zmask = 0.
REQ-021 PULL_MODE 3: bus_q holds last driven value with bus_zmask = 0 for the first DECAY consecutive undriven cycles, then bus_zmask = all ones while bus_q keeps its value.
REQ-022 Keeper decay counter SHALL clear on any cycle with drv_en != 0 and saturate at DECAY.
REQ-023 Any driven cycle SHALL set bus_zmask = 0.
REQ-024 conflict_cnt SHALL increment by 1 on each cycle where the next conflict_mask != 0 and SHALL saturate at 16'hFFFF.
REQ-025 When cnt_clr = 1, conflict_cnt SHALL become 0 regardless of a simultaneous conflict.
REQ-026 NET_MODE or PULL_MODE values outside the defined range SHALL be rejected at elaboration.

Reset
REQ-027 While rst = 1: conflict_mask = 0, conflict_cnt = 0, decay counter = 0.
REQ-028 While rst = 1 with PULL_MODE 1: bus_q = 0, bus_zmask = 0.
REQ-029 While rst = 1 with PULL_MODE 2: bus_q = all ones, bus_zmask = 0.
REQ-030 While rst = 1 with PULL_MODE 0 or 3: bus_q = 0, bus_zmask = all ones.
REQ-031 Reset asserted mid-operation SHALL override all state immediately; the first post-reset edge SHALL resolve normally.

Structure
REQ-032 NET_MODE/PULL_MODE encodings and the conflict_cnt width constant SHALL live in shared package tribus_pkg.
REQ-033 Per-bit resolution (value, driven, conflict) SHALL be one combinational sub-module tribus_bit_resolve, instantiated WIDTH times.

Verification
REQ-034 Scenario: TRI, WIDTH=8; ch0=8'hA5, ch2=8'hA4 enabled -> bus_q=8'hA5, conflict_mask=8'h01, conflict_cnt 0->1.
REQ-035 Scenario: WAND, ch1=8'hF0, ch3=8'h3C -> bus_q=8'h30. Same drivers under WOR -> bus_q=8'hFC. Both modes: conflict_mask=0.
REQ-036 Scenario: PULL_MODE 1 and 2, drv_en=0 after a driven 8'h5A -> bus_q=8'h00 and 8'hFF respectively, bus_zmask=0.
REQ-037 Scenario: PULL_MODE 3, DECAY=4; drive 8'h3C then release.
- bus_q=8'h3C, bus_zmask=0 for 4 cycles, then bus_zmask=8'hFF.
- Re-drive 8'h11 -> bus_zmask=0, bus_q=8'h11.
REQ-038 Scenario: conflict every cycle for 70000 cycles -> conflict_cnt=16'hFFFF. Then cnt_clr with conflict -> 0.
REQ-039 Scenario: rst pulsed mid-traffic with PULL_MODE 2 -> bus_q=8'hFF, conflict_cnt=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/tribus_pkg.sv
// rtl/tribus_pkg.sv - shared encodings and constants for the tri-state bus resolver
package tribus_pkg;

    localparam int NET_TRI   = 0;
    localparam int NET_WAND  = 1;
    localparam int NET_WOR   = 2;

    localparam int PULL_NONE = 0;
    localparam int PULL_DOWN = 1;
    localparam int PULL_UP   = 2;
    localparam int PULL_KEEP = 3;

    localparam int CNT_W     = 16;
    localparam int DECAY_W   = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/tribus_bit_resolve.sv
// rtl/tribus_bit_resolve.sv - combinational resolution of one bus bit across all channels
module tribus_bit_resolve
    import tribus_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int NET_MODE = NET_TRI
) (
    input  logic [NCH-1:0] i_en,
    input  logic [NCH-1:0] i_bit,
    output logic           o_value,
    output logic           o_driven,
    output logic           o_conflict
);

    logic w_and;
    logic w_or;
    logic w_first;

    always_comb begin
        w_and   = 1'b1;
        w_or    = 1'b0;
        w_first = 1'b0;
        // descending scan so the lowest enabled index is the last writer
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i_en[i]) begin
                w_and   = w_and & i_bit[i];
                w_or    = w_or | i_bit[i];
                w_first = i_bit[i];
            end
        end
    end

    assign o_driven = |i_en;

    always_comb begin
        o_value    = w_first;
        o_conflict = 1'b0;
        if (NET_MODE == NET_WAND) begin
            o_value = w_and;
        end else if (NET_MODE == NET_WOR) begin
            o_value = w_or;
        end else begin
            // some enabled driver is 1 and some is 0
            o_conflict = w_or & ~w_and;
        end
    end

endmodule

// File: rtl/tribus_resolver.sv
// rtl/tribus_resolver.sv - registered multi-channel bus resolver with pull/keeper and conflict counting
module tribus_resolver
    import tribus_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NCH       = 4,
    parameter int NET_MODE  = 0,
    parameter int PULL_MODE = 0,
    parameter int DECAY     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       drv_en,
    input  logic [NCH*WIDTH-1:0] drv_data,
    input  logic                 cnt_clr,
    output logic [WIDTH-1:0]     bus_q,
    output logic [WIDTH-1:0]     bus_zmask,
    output logic [WIDTH-1:0]     conflict_mask,
    output logic [CNT_W-1:0]     conflict_cnt
);

    generate
        if (NET_MODE < NET_TRI || NET_MODE > NET_WOR) begin : g_bad_net
            $error("tribus_resolver: NET_MODE out of range");
        end
        if (PULL_MODE < PULL_NONE || PULL_MODE > PULL_KEEP) begin : g_bad_pull
            $error("tribus_resolver: PULL_MODE out of range");
        end
        if (WIDTH < 1 || WIDTH > 64 || NCH < 2 || NCH > 16) begin : g_bad_size
            $error("tribus_resolver: WIDTH or NCH out of range");
        end
        if (DECAY < 1 || DECAY > 65535) begin : g_bad_decay
            $error("tribus_resolver: DECAY out of range");
        end
    endgenerate

    localparam logic [WIDTH-1:0]   ONES    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   ZEROS   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   RST_Q   = (PULL_MODE == PULL_UP) ? ONES : ZEROS;
    localparam logic [WIDTH-1:0]   RST_Z   = (PULL_MODE == PULL_NONE || PULL_MODE == PULL_KEEP) ? ONES : ZEROS;
    localparam logic [DECAY_W-1:0] DECAY_L = DECAY_W'(DECAY);

    logic [WIDTH-1:0]   w_value;
    logic [WIDTH-1:0]   w_driven_bits;
    logic [WIDTH-1:0]   w_conflict;
    logic               w_driven;

    logic [WIDTH-1:0]   r_bus_q;
    logic [WIDTH-1:0]   r_bus_zmask;
    logic [WIDTH-1:0]   r_conflict_mask;
    logic [CNT_W-1:0]   r_conflict_cnt;
    logic [DECAY_W-1:0] r_decay;

    genvar b, c;
    generate
        for (b = 0; b < WIDTH; b++) begin : g_bit
            logic [NCH-1:0] w_ch_bit;
            for (c = 0; c < NCH; c++) begin : g_ch
                assign w_ch_bit[c] = drv_data[c*WIDTH + b];
            end
            tribus_bit_resolve #(
                .NCH      (NCH),
                .NET_MODE (NET_MODE)
            ) u_bit (
                .i_en       (drv_en),
                .i_bit      (w_ch_bit),
                .o_value    (w_value[b]),
                .o_driven   (w_driven_bits[b]),
                .o_conflict (w_conflict[b])
            );
        end
    endgenerate

    assign w_driven = |w_driven_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_q         <= RST_Q;
            r_bus_zmask     <= RST_Z;
            r_conflict_mask <= ZEROS;
            r_decay         <= '0;
        end else if (w_driven) begin
            r_bus_q         <= w_value;
            r_bus_zmask     <= ZEROS;
            r_conflict_mask <= w_conflict;
            r_decay         <= '0;
        end else begin
            r_conflict_mask <= ZEROS;
            case (PULL_MODE)
                PULL_DOWN: begin
                    r_bus_q     <= ZEROS;
                    r_bus_zmask <= ZEROS;
                end
                PULL_UP: begin
                    r_bus_q     <= ONES;
                    r_bus_zmask <= ZEROS;
                end
                PULL_KEEP: begin
                    // value is kept for DECAY undriven cycles, then reported as floating
                    r_bus_zmask <= (r_decay >= DECAY_L) ? ONES : ZEROS;
                    if (r_decay < DECAY_L) begin
                        r_decay <= r_decay + 1'b1;
                    end
                end
                default: begin
                    r_bus_zmask <= ONES;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (cnt_clr) begin
            r_conflict_cnt <= '0;
        end else if (w_driven && (|w_conflict)) begin
            r_conflict_cnt <= sat_inc(r_conflict_cnt);
        end
    end

    assign bus_q         = r_bus_q;
    assign bus_zmask     = r_bus_zmask;
    assign conflict_mask = r_conflict_mask;
    assign conflict_cnt  = r_conflict_cnt;

endmodule

// File: tb/tb_tribus_resolver.sv
// tb/tb_tribus_resolver.sv - directed self-checking bench over six resolver configurations
module tb_tribus_resolver;

    // instance map: 0 TRI/none, 1 WAND, 2 WOR, 3 TRI/pull-down, 4 TRI/pull-up, 5 TRI/keeper DECAY=4
    logic        clk;
    logic        rst;
    logic [3:0]  drv_en;
    logic [31:0] drv_data;
    logic        cnt_clr;
    logic [7:0]  q [6];
    logic [7:0]  z [6];
    logic [7:0]  m [6];
    logic [15:0] n [6];

    int total;
    int bad;

    genvar g;
    generate
        for (g = 0; g < 6; g++) begin : g_dut
            tribus_resolver #(
                .WIDTH     (8),
                .NCH       (4),
                .NET_MODE  ((g == 1) ? 1 : (g == 2) ? 2 : 0),
                .PULL_MODE ((g >= 3) ? g - 2 : 0),
                .DECAY     ((g == 5) ? 4 : 16)
            ) u_dut (
                .clk           (clk),
                .rst           (rst),
                .drv_en        (drv_en),
                .drv_data      (drv_data),
                .cnt_clr       (cnt_clr),
                .bus_q         (q[g]),
                .bus_zmask     (z[g]),
                .conflict_mask (m[g]),
                .conflict_cnt  (n[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; drv_en = 4'h0; drv_data = 32'h0; cnt_clr = 1'b0;
        #2;
        total++;
        if ({q[0], z[0], m[0], n[0]} !== {8'h00, 8'hFF, 8'h00, 16'h0000}) begin
            bad++; $display("FAIL reset_none got=%h exp=%h", {q[0], z[0], m[0], n[0]}, {8'h00, 8'hFF, 8'h00, 16'h0000});
        end
        total++;
        if ({q[3], z[3]} !== {8'h00, 8'h00}) begin
            bad++; $display("FAIL reset_pd got=%h exp=%h", {q[3], z[3]}, 16'h0000);
        end
        total++;
        if ({q[4], z[4]} !== {8'hFF, 8'h00}) begin
            bad++; $display("FAIL reset_pu got=%h exp=%h", {q[4], z[4]}, 16'hFF00);
        end
        total++;
        if ({q[5], z[5]} !== {8'h00, 8'hFF}) begin
            bad++; $display("FAIL reset_keep got=%h exp=%h", {q[5], z[5]}, 16'h00FF);
        end
        #1 rst = 1'b0;
        step();
    endtask

    task automatic test_tri_conflict();
        drv_en = 4'b0101; drv_data = 32'h00A4_00A5;
        step();
        total++;
        if ({q[0], z[0], m[0], n[0]} !== {8'hA5, 8'h00, 8'h01, 16'h0001}) begin
            bad++; $display("FAIL tri_conflict got=%h exp=%h", {q[0], z[0], m[0], n[0]}, {8'hA5, 8'h00, 8'h01, 16'h0001});
        end
        total++;
        if ({q[1], m[1], n[1]} !== {8'hA4, 8'h00, 16'h0000}) begin
            bad++; $display("FAIL wand_a5a4 got=%h exp=%h", {q[1], m[1], n[1]}, {8'hA4, 8'h00, 16'h0000});
        end
        total++;
        if ({q[2], m[2]} !== {8'hA5, 8'h00}) begin
            bad++; $display("FAIL wor_a5a4 got=%h exp=%h", {q[2], m[2]}, 16'hA500);
        end
    endtask

    task automatic test_wand_wor();
        drv_en = 4'b1010; drv_data = 32'h3C00_F000;
        step();
        total++;
        if ({q[1], z[1], m[1]} !== {8'h30, 8'h00, 8'h00}) begin
            bad++; $display("FAIL wand got=%h exp=%h", {q[1], z[1], m[1]}, 24'h300000);
        end
        total++;
        if ({q[2], z[2], m[2]} !== {8'hFC, 8'h00, 8'h00}) begin
            bad++; $display("FAIL wor got=%h exp=%h", {q[2], z[2], m[2]}, 24'hFC0000);
        end
        total++;
        if ({q[0], m[0], n[0]} !== {8'hF0, 8'hCC, 16'h0002}) begin
            bad++; $display("FAIL tri_ch1_ch3 got=%h exp=%h", {q[0], m[0], n[0]}, {8'hF0, 8'hCC, 16'h0002});
        end
    endtask

    task automatic test_pull();
        drv_en = 4'b0001; drv_data = 32'h0000_005A;
        step();
        total++;
        if ({q[3], q[4]} !== {8'h5A, 8'h5A}) begin
            bad++; $display("FAIL pull_driven got=%h exp=%h", {q[3], q[4]}, 16'h5A5A);
        end
        drv_en = 4'b0000;
        step();
        total++;
        if ({q[3], z[3]} !== {8'h00, 8'h00}) begin
            bad++; $display("FAIL pull_down got=%h exp=%h", {q[3], z[3]}, 16'h0000);
        end
        total++;
        if ({q[4], z[4]} !== {8'hFF, 8'h00}) begin
            bad++; $display("FAIL pull_up got=%h exp=%h", {q[4], z[4]}, 16'hFF00);
        end
        total++;
        if ({q[0], z[0], m[0]} !== {8'h5A, 8'hFF, 8'h00}) begin
            bad++; $display("FAIL float_hold got=%h exp=%h", {q[0], z[0], m[0]}, 24'h5AFF00);
        end
    endtask

    task automatic test_keeper();
        drv_en = 4'b0001; drv_data = 32'h0000_003C;
        step();
        total++;
        if ({q[5], z[5]} !== {8'h3C, 8'h00}) begin
            bad++; $display("FAIL keep_drive got=%h exp=%h", {q[5], z[5]}, 16'h3C00);
        end
        drv_en = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({q[5], z[5]} !== {8'h3C, 8'h00}) begin
                bad++; $display("FAIL keep_hold%0d got=%h exp=%h", i, {q[5], z[5]}, 16'h3C00);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if ({q[5], z[5]} !== {8'h3C, 8'hFF}) begin
                bad++; $display("FAIL keep_decayed%0d got=%h exp=%h", i, {q[5], z[5]}, 16'h3CFF);
            end
        end
        drv_en = 4'b0001; drv_data = 32'h0000_0011;
        step();
        total++;
        if ({q[5], z[5]} !== {8'h11, 8'h00}) begin
            bad++; $display("FAIL keep_redrive got=%h exp=%h", {q[5], z[5]}, 16'h1100);
        end
    endtask

    task automatic test_saturate();
        drv_en = 4'b0101; drv_data = 32'h00A4_00A5; cnt_clr = 1'b1;
        step();
        total++;
        if ({m[0], n[0]} !== {8'h01, 16'h0000}) begin
            bad++; $display("FAIL clr_with_conflict got=%h exp=%h", {m[0], n[0]}, 24'h010000);
        end
        cnt_clr = 1'b0;
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1;
        total++;
        if (n[0] !== 16'hFFFE) begin
            bad++; $display("FAIL cnt_fffe got=%h exp=%h", n[0], 16'hFFFE);
        end
        for (int i = 0; i < 70000 - 65534; i++) @(posedge clk);
        #1;
        total++;
        if (n[0] !== 16'hFFFF) begin
            bad++; $display("FAIL cnt_saturate got=%h exp=%h", n[0], 16'hFFFF);
        end
        cnt_clr = 1'b1;
        step();
        total++;
        if (n[0] !== 16'h0000) begin
            bad++; $display("FAIL cnt_clr got=%h exp=%h", n[0], 16'h0000);
        end
        cnt_clr = 1'b0;
        step();
        total++;
        if (n[0] !== 16'h0001) begin
            bad++; $display("FAIL cnt_after_clr got=%h exp=%h", n[0], 16'h0001);
        end
    endtask

    task automatic test_reset_mid();
        step();
        total++;
        if ({q[4], n[0]} !== {8'hA5, 16'h0002}) begin
            bad++; $display("FAIL pre_reset got=%h exp=%h", {q[4], n[0]}, 24'hA50002);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({q[4], z[4], n[4]} !== {8'hFF, 8'h00, 16'h0000}) begin
            bad++; $display("FAIL async_reset_pu got=%h exp=%h", {q[4], z[4], n[4]}, 32'hFF000000);
        end
        total++;
        if ({q[0], z[0], m[0], n[0]} !== {8'h00, 8'hFF, 8'h00, 16'h0000}) begin
            bad++; $display("FAIL async_reset_tri got=%h exp=%h", {q[0], z[0], m[0], n[0]}, 40'h00FF000000);
        end
        #1 rst = 1'b0;
        drv_en = 4'b0001; drv_data = 32'h0000_0077;
        step();
        total++;
        if ({q[0], z[0], q[4], z[4], n[0]} !== {8'h77, 8'h00, 8'h77, 8'h00, 16'h0000}) begin
            bad++; $display("FAIL post_reset got=%h exp=%h", {q[0], z[0], q[4], z[4], n[0]}, 48'h770077000000);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_tri_conflict();
        test_wand_wor();
        test_pull();
        test_keeper();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
